// File: rtl/sr_flag_arbiter_pkg.sv
// sr_flag_arbiter_pkg: FSM states and {S,R} command encoding shared by the SR flag arbiter.
package sr_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, APPLY} state_t;
   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_RST  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_ILL  = 2'b11;
   // Set-and-reset together resolves to reset.
   function automatic logic sr_next(input logic [1:0] cmd, input logic cur);
      return (cmd == CMD_HOLD) ? cur :
             (cmd == CMD_SET) ? 1'b1 :
             (cmd == CMD_RST || cmd == CMD_ILL) ? 1'b0 : cur;
   endfunction
endpackage

// File: rtl/sr_flag_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searching from the requester after 'last'.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx
);
   int   k;
   logic found;
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      k      = 0;
      for (int i = 1; i <= N; i++) begin
         k = (int'(last) + i) % N;
         if (!found && req[k]) begin
            found     = 1'b1;
            onehot[k] = 1'b1;
            idx       = W'(k);
         end
      end
   end
endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbitration of SR set/reset commands onto a shared flag bank.
// Optional `SR_ARB_ILLEGAL_ERR_EN adds a sticky ERR output for S=1,R=1 commands.
module sr_flag_arbiter import sr_arb_pkg::*; #(
   parameter int NREQ   = 4,
   parameter int NFLAGS = 8,
   localparam int IW    = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
   localparam int PW    = $clog2(NREQ)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ-1:0]      S_IN,
   input  logic [NREQ-1:0]      R_IN,
   input  logic [NREQ*IW-1:0]   IDX,
   output logic [NREQ-1:0]      GNT,
   output logic [NREQ-1:0]      ACK,
   output logic [NFLAGS-1:0]    FLAGS,
   output logic                 BUSY
`ifdef SR_ARB_ILLEGAL_ERR_EN
   ,
   output logic                 ERR
`endif
);
   state_t          state, state_n;
   logic [NREQ-1:0] win, pick_oh, pick_req;
   logic [PW-1:0]   ptr, pick_idx;
   logic            s_q, r_q, load;
   logic [IW-1:0]   idx_q;

   // The winner being applied is excluded so the next pick goes to someone else.
   assign pick_req = (state == APPLY) ? REQ & ~win : REQ;

   rr_pick #(.N(NREQ), .W(PW)) u_pick (
      .req    (pick_req),
      .last   (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx)
   );

   always_comb begin
      state_n = (state == GRANT) ? APPLY : (|pick_req) ? GRANT : IDLE;
      load    = (state != GRANT) && (|pick_req);
      GNT     = (state == IDLE) ? '0 : win;
      ACK     = (state == APPLY) ? win : '0;
      BUSY    = (state != IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         ptr   <= PW'(NREQ - 1);
         win   <= '0;
         s_q   <= 1'b0;
         r_q   <= 1'b0;
         idx_q <= '0;
         FLAGS <= '0;
      end else begin
         state <= state_n;
         if (load) begin
            win   <= pick_oh;
            ptr   <= pick_idx;
            s_q   <= S_IN[pick_idx];
            r_q   <= R_IN[pick_idx];
            idx_q <= IDX[int'(pick_idx)*IW +: IW];
         end
         if (state == APPLY && int'(idx_q) < NFLAGS)
            FLAGS[idx_q] <= sr_next({s_q, r_q}, FLAGS[idx_q]);
      end
   end

`ifdef SR_ARB_ILLEGAL_ERR_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) ERR <= 1'b0;
      else if (state == APPLY && {s_q, r_q} == CMD_ILL) ERR <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed checks of latency, round-robin order, SR rules, out-of-range and reset abort.
// NFLAGS=6 so a 3-bit index can name out-of-range flags 6 and 7.
module tb_sr_flag_arbiter;
   localparam int NREQ = 4, NFLAGS = 6, IW = 3;
   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic [NREQ-1:0]     REQ = '0, S_IN = '0, R_IN = '0;
   logic [NREQ*IW-1:0]  IDX = '0;
   logic [NREQ-1:0]     GNT, ACK;
   logic [NFLAGS-1:0]   FLAGS;
   logic                BUSY;
`ifdef SR_ARB_ILLEGAL_ERR_EN
   logic                ERR;
`endif
   int   passed = 0, total = 0, nack = 0;
   int   order[8], ack_cyc[8];
   logic gnt_bad, ack_seen;

   always #5 CLK = ~CLK;

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS)) dut (
      .CLK (CLK), .RST (RST), .REQ (REQ), .S_IN (S_IN), .R_IN (R_IN), .IDX (IDX),
      .GNT (GNT), .ACK (ACK), .FLAGS (FLAGS), .BUSY (BUSY)
`ifdef SR_ARB_ILLEGAL_ERR_EN
      , .ERR (ERR)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cmd(input int i, input logic s, input logic r, input int idx);
      S_IN[i] = s;
      R_IN[i] = r;
      IDX[i*IW +: IW] = IW'(idx);
   endtask

   // Runs until n ACKs or the budget expires; acked requesters drop REQ unless held, and re-raise next cycle if rearmed.
   task automatic serve(input int n, input logic [3:0] hold, input logic [3:0] rearm, input int budget);
      logic [3:0] pend;
      int cyc;
      pend = '0;
      cyc = 0;
      nack = 0;
      gnt_bad = 1'b0;
      while (nack < n && cyc < budget) begin
         @(negedge CLK);
         cyc++;
         REQ = REQ | pend;
         pend = '0;
         if (!$onehot0(GNT)) gnt_bad = 1'b1;
         for (int b = 0; b < NREQ; b++)
            if (ACK[b] && nack < 8) begin
               order[nack] = b;
               ack_cyc[nack] = cyc;
               nack++;
               if (!hold[b]) begin
                  REQ[b] = 1'b0;
                  pend[b] = rearm[b];
               end
            end
      end
      chk("ack_count", nack, n);
      chk("gnt_onehot", gnt_bad, 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      REQ = '0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk("rst_gnt", GNT, 0);
      chk("rst_ack", ACK, 0);
      chk("rst_flags", FLAGS, 0);
      chk("rst_busy", BUSY, 0);
      RST = 1'b0;

      // single request: GNT in cycle 1, ACK in cycle 2, flag visible after APPLY
      cmd(0, 1, 0, 3);
      REQ = 4'b0001;
      @(negedge CLK);
      chk("single_gnt", GNT, 4'b0001);
      chk("single_ack0", ACK, 0);
      chk("single_busy", BUSY, 1);
      @(negedge CLK);
      chk("single_ack", ACK, 4'b0001);
      chk("single_gnt_hold", GNT, 4'b0001);
      REQ = '0;
      @(negedge CLK);
      chk("single_flags", FLAGS, 6'h08);
      chk("single_idle", BUSY, 0);
      chk("single_ack_end", ACK, 0);

      // all four at once after reset: order 0..3, 2 cycles apart
      do_reset();
      chk("rst2_flags", FLAGS, 0);
      for (int i = 0; i < NREQ; i++) cmd(i, 1, 0, i);
      REQ = 4'b1111;
      serve(4, 4'b0000, 4'b0000, 20);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i);
      chk("rr_first_latency", ack_cyc[0], 2);
      for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 2);
      REQ = '0;
      @(negedge CLK);
      chk("rr_flags", FLAGS, 6'h0F);
      chk("rr_idle", BUSY, 0);

      // S=1,R=1 from requester 1 clears flag 3
      S_IN = '0; R_IN = '0;
`ifdef SR_ARB_ILLEGAL_ERR_EN
      chk("err_before", ERR, 0);
`endif
      cmd(1, 1, 1, 3);
      REQ = 4'b0010;
      serve(1, 4'b0000, 4'b0000, 10);
      chk("ill_who", order[0], 1);
      @(negedge CLK);
      chk("ill_flags", FLAGS, 6'h07);
`ifdef SR_ARB_ILLEGAL_ERR_EN
      chk("err_after", ERR, 1);
`endif

      // plain reset and hold commands
      S_IN = '0; R_IN = '0;
      cmd(3, 0, 1, 0);
      REQ = 4'b1000;
      serve(1, 4'b0000, 4'b0000, 10);
      @(negedge CLK);
      chk("rst_cmd_flags", FLAGS, 6'h06);
      cmd(2, 0, 0, 1);
      REQ = 4'b0100;
      serve(1, 4'b0000, 4'b0000, 10);
      @(negedge CLK);
      chk("hold_flags", FLAGS, 6'h06);

      // command changed after latching has no effect
      S_IN = '0; R_IN = '0;
      cmd(0, 1, 0, 4);
      REQ = 4'b0001;
      @(negedge CLK);
      chk("latch_gnt", GNT, 4'b0001);
      cmd(0, 0, 1, 5);
      @(negedge CLK);
      chk("latch_ack", ACK, 4'b0001);
      REQ = '0;
      @(negedge CLK);
      chk("latch_flags", FLAGS, 6'h16);

      // out-of-range index still ACKs, leaves FLAGS alone
      S_IN = '0; R_IN = '0;
      cmd(3, 1, 0, 7);
      REQ = 4'b1000;
      serve(1, 4'b0000, 4'b0000, 10);
      chk("oor_who", order[0], 3);
      @(negedge CLK);
      chk("oor_flags", FLAGS, 6'h16);

      // requester 2 holds, requester 0 re-requests: alternation 0,2,0,2
      S_IN = '0; R_IN = '0;
      cmd(0, 0, 0, 0);
      cmd(2, 1, 0, 5);
      REQ = 4'b0101;
      serve(4, 4'b0100, 4'b0001, 30);
      chk("alt0", order[0], 0);
      chk("alt1", order[1], 2);
      chk("alt2", order[2], 0);
      chk("alt3", order[3], 2);
      REQ = '0;
      @(negedge CLK);
      chk("alt_flags", FLAGS, 6'h36);
      chk("alt_idle", BUSY, 0);

      // reset during GRANT aborts the set to flag 5
      do_reset();
      S_IN = '0; R_IN = '0;
      cmd(0, 1, 0, 5);
      REQ = 4'b0001;
      @(negedge CLK);
      chk("abort_gnt", GNT, 4'b0001);
      RST = 1'b1;
      #1;
      chk("abort_async_gnt", GNT, 0);
      chk("abort_async_busy", BUSY, 0);
      REQ = '0;
      ack_seen = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (ACK != 0) ack_seen = 1'b1;
      end
      chk("abort_no_ack", ack_seen, 0);
      chk("abort_flags", FLAGS, 0);
      chk("abort_idle", BUSY, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
